// File: rtl/mac_row_os_collector.sv
// rtl/mac_row_os_collector.sv - captures skewed per-column OS psums, buffers full rows, streams them column by column
module mac_row_os_collector #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int ROWS    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [psum_bw*col-1:0]     os_out,
  input  logic [col-1:0]             os_valid,
  output logic [psum_bw-1:0]         out_data,
  output logic [$clog2(col)-1:0]     out_col,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       collect_ready,
  output logic [col-1:0]             slot_valid,
  output logic                       overflow,
  output logic [7:0]                 row_cnt
);

  localparam int CW = $clog2(col);
  localparam int PW = $clog2(ROWS);
  localparam int NW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(col - 1);
  localparam logic [NW-1:0] ROWS_C   = NW'(ROWS);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [psum_bw-1:0]  r_slot [col];
  logic [col-1:0]      r_slot_valid;
  logic [psum_bw-1:0]  r_row_buf [ROWS][col];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [NW-1:0]       r_count;
  logic [CW-1:0]       r_col_cnt;
  logic [7:0]          r_row_cnt;
  logic                r_overflow;

  logic                w_push;
  logic                w_fire;
  logic                w_pop;
  logic [NW-1:0]       w_count_nxt;

  // A full set of slots moves into the row buffer only if there is room before this edge
  assign w_push      = (&r_slot_valid) && (r_count < ROWS_C);
  assign w_fire      = (r_state == S_SEND) && out_ready;
  assign w_pop       = w_fire && (r_col_cnt == LAST_COL);
  assign w_count_nxt = r_count + NW'(w_push) - NW'(w_pop);

  // Capture slots: a strobe on a slot that is being promoted refills it instead of overflowing
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) r_slot[i] <= '0;
      r_slot_valid <= '0;
      r_overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (os_valid[i] && (w_push || !r_slot_valid[i]))
          r_slot[i] <= os_out[psum_bw*i +: psum_bw];
      end
      r_slot_valid <= w_push ? os_valid : (r_slot_valid | os_valid);
      if (|(os_valid & r_slot_valid & ~{col{w_push}}))
        r_overflow <= 1'b1;
    end
  end

  // Row buffer write on promotion
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int i = 0; i < col; i++) r_row_buf[r][i] <= '0;
    end else if (w_push) begin
      for (int i = 0; i < col; i++) r_row_buf[r_wr_ptr][i] <= r_slot[i];
    end
  end

  // Ring pointers, occupancy, column counter and drained-row counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_fire) r_col_cnt <= w_pop ? '0 : r_col_cnt + CW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_row_cnt <= r_row_cnt + 8'd1;
      end
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Drain FSM next state: keep streaming across row boundaries while rows remain
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_nxt = S_SEND;
      S_SEND: if (w_pop && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stream outputs come straight from registered state, so they hold under backpressure
  always_comb begin
    out_valid = (r_state == S_SEND);
    out_data  = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = r_row_buf[r_rd_ptr][r_col_cnt];
      out_col  = r_col_cnt;
      out_last = (r_col_cnt == LAST_COL);
    end
  end

  assign collect_ready = (r_count < ROWS_C);
  assign slot_valid    = r_slot_valid;
  assign overflow      = r_overflow;
  assign row_cnt       = r_row_cnt;

endmodule

// File: tb/tb_mac_row_os_collector.sv
// tb/tb_mac_row_os_collector.sv - directed self-checking bench for mac_row_os_collector
module tb_mac_row_os_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] os_out;
  logic [7:0]   os_valid;
  logic [15:0]  out_data;
  logic [2:0]   out_col;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         collect_ready;
  logic [7:0]   slot_valid;
  logic         overflow;
  logic [7:0]   row_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  mac_row_os_collector #(.psum_bw(16), .col(8), .ROWS(2)) dut (
    .clk(clk), .reset(reset), .os_out(os_out), .os_valid(os_valid),
    .out_data(out_data), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .collect_ready(collect_ready), .slot_valid(slot_valid),
    .overflow(overflow), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; os_valid = '0; os_out = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic set_col(input int i, input logic [15:0] v);
    os_out[16*i +: 16] = v;
  endtask

  // Waits (bounded) for the first word, then expects n words back to back
  task automatic drain(input int n, input string tag);
    int w = 0;
    while (!out_valid && w < 20) begin tick(); w++; end
    chk({tag, "_first_word_timeout"}, out_valid, 1);
    for (int k = 0; k < n; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, e);
      chk({tag, "_col"}, out_col, k % 8);
      chk({tag, "_last"}, out_last, (k % 8) == 7);
      tick();
    end
  endtask

  initial begin
    int seen;
    reset = 1'b0; os_valid = '0; os_out = '0; out_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_slot_valid", slot_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_row_cnt", row_cnt, 0);
    chk("rst_collect_ready", collect_ready, 1);

    // Aligned row
    do_reset();
    for (int i = 0; i < 8; i++) begin set_col(i, 16'h1000 + 16'(i)); exp_q.push_back(16'h1000 + 16'(i)); end
    os_valid = 8'hFF;
    tick();
    os_valid = '0;
    chk("al_slot_full", slot_valid, 8'hFF);
    chk("al_no_out_yet", out_valid, 0);
    tick();
    chk("al_promoted", slot_valid, 0);
    drain(8, "al");
    chk("al_row_cnt", row_cnt, 1);
    chk("al_idle", out_valid, 0);

    // Skewed flush
    do_reset();
    for (int i = 0; i < 8; i++) begin set_col(i, 16'hA0A0 ^ 16'(i)); exp_q.push_back(16'hA0A0 ^ 16'(i)); end
    for (int i = 0; i < 8; i++) begin
      os_valid = 8'(1 << i);
      tick();
      chk("sk_slot_fill", slot_valid, (32'd2 << i) - 1);
      chk("sk_no_out", out_valid, 0);
    end
    os_valid = '0;
    drain(8, "sk");
    chk("sk_row_cnt", row_cnt, 1);

    // Backpressure with three rows
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin set_col(i, 16'h2000 + 16'(r*16 + i)); exp_q.push_back(16'h2000 + 16'(r*16 + i)); end
      os_valid = 8'hFF;
      tick();
      os_valid = '0;
      tick();
    end
    tick(); tick();
    chk("bp_collect_ready", collect_ready, 0);
    chk("bp_slots_held", slot_valid, 8'hFF);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 16'h2000);
    tick();
    chk("bp_hold_data2", out_data, 16'h2000);
    chk("bp_hold_col", out_col, 0);
    out_ready = 1'b1;
    drain(24, "bp");
    chk("bp_row_cnt", row_cnt, 3);
    chk("bp_idle", out_valid, 0);

    // Overflow: second strobe on column 3 is dropped
    do_reset();
    set_col(3, 16'h0011);
    os_valid = 8'h08;
    tick();
    chk("ov_not_yet", overflow, 0);
    set_col(3, 16'h0022);
    tick();
    chk("ov_set", overflow, 1);
    for (int i = 0; i < 8; i++) if (i != 3) set_col(i, 16'h0100 + 16'(i));
    os_valid = 8'hF7;
    tick();
    os_valid = '0;
    chk("ov_sticky", overflow, 1);
    for (int i = 0; i < 8; i++) exp_q.push_back(i == 3 ? 16'h0011 : 16'h0100 + 16'(i));
    drain(8, "ov");
    chk("ov_sticky_end", overflow, 1);

    // Capture on the promotion edge
    do_reset();
    for (int i = 0; i < 8; i++) begin set_col(i, 16'h3000 + 16'(i)); exp_q.push_back(16'h3000 + 16'(i)); end
    os_valid = 8'hFF;
    tick();
    set_col(0, 16'hBEEF);
    os_valid = 8'h01;
    tick();
    chk("pe_no_overflow", overflow, 0);
    chk("pe_slot", slot_valid, 8'h01);
    for (int i = 1; i < 8; i++) set_col(i, 16'h4000 + 16'(i));
    os_valid = 8'hFE;
    tick();
    os_valid = '0;
    exp_q.push_back(16'hBEEF);
    for (int i = 1; i < 8; i++) exp_q.push_back(16'h4000 + 16'(i));
    drain(16, "pe");
    chk("pe_row_cnt", row_cnt, 2);
    chk("pe_overflow_end", overflow, 0);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 8; i++) begin set_col(i, 16'h5000 + 16'(i)); exp_q.push_back(16'h5000 + 16'(i)); end
    os_valid = 8'hFF;
    tick();
    os_valid = '0;
    begin
      int w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
    end
    chk("md_started", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      chk("md_data", out_data, exp_q.pop_front());
      os_valid = (k < 2) ? 8'h01 : 8'h00;
      tick();
    end
    os_valid = '0;
    chk("md_pre_overflow", overflow, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("md_out_valid", out_valid, 0);
    chk("md_slot_valid", slot_valid, 0);
    chk("md_row_cnt", row_cnt, 0);
    chk("md_overflow", overflow, 0);
    chk("md_collect_ready", collect_ready, 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("md_no_leftover", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
